// File: rtl/lcd_frame_reader.sv
// lcd_frame_reader: pulls RGB565 pixels from the SD-image pixel FIFO in step
// with the panel timing generator, expands them to RGB888 and drives the
// DE-qualified LCD pixel bus. It locks to the first full frame after reset,
// tracks the pixel position, and substitutes a fill colour on FIFO underflow.
//
// Ports:
//   clk, rst               pixel clock, synchronous active-high reset
//   h_valid, v_valid       line / frame active from the timing generator
//   fifo_empty, fifo_dout  pixel FIFO status and RGB565 data (1-cycle read latency)
//   fifo_rd_en             FIFO pop (combinational)
//   lcd_de, lcd_rgb        panel data enable and RGB888 pixel (2 cycles after act)
//   frame_start            one-cycle pulse after each v_valid rise
//   x_cnt, y_cnt           registered pixel / line position
//   underflow              sticky underflow flag
//   underflow_cnt          saturating count of underflowed pixels
//
// Optional build macro LCD_FRAME_READER_COLORBAR_EN: fill pixels (before lock
// or on underflow) show an 8-bar test pattern chosen by x_cnt[9:7] instead of
// FILL_RGB.
module lcd_frame_reader #(
  parameter int unsigned H_ACT    = 1024,
  parameter int unsigned V_ACT    = 768,
  parameter logic [23:0] FILL_RGB = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        h_valid,
  input  logic        v_valid,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_dout,
  output logic        fifo_rd_en,
  output logic        lcd_de,
  output logic [23:0] lcd_rgb,
  output logic        frame_start,
  output logic [10:0] x_cnt,
  output logic [9:0]  y_cnt,
  output logic        underflow,
  output logic [15:0] underflow_cnt
);

  localparam int unsigned XW   = 11;
  localparam int unsigned YW   = 10;
  localparam int unsigned UCW  = 16;
  localparam int unsigned RGBW = 24;

  localparam logic [XW-1:0]  X_MAX  = XW'(H_ACT);
  localparam logic [YW-1:0]  Y_MAX  = YW'(V_ACT);
  localparam logic [UCW-1:0] UC_MAX = {UCW{1'b1}};

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    RUN       = 1'b1
  } state_t;

  state_t state;

  logic v_valid_d;
  logic h_valid_d;
  logic de_p;      // act & in_range, one cycle behind
  logic rd_p;      // a read was issued last cycle, so fifo_dout is live now

  logic act;
  logic vs_rise;
  logic h_fall;
  logic in_range;
  logic running;
  logic uf_hit;
  logic [RGBW-1:0] fill_rgb_c;

  // RGB565 -> RGB888 by replicating each channel's MSBs into the new LSBs.
  function automatic logic [RGBW-1:0] rgb565_to_888(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  // Frame/line edge detection and read qualification.
  assign act        = h_valid & v_valid;
  assign vs_rise    = v_valid & ~v_valid_d;
  assign h_fall     = ~h_valid & h_valid_d;
  assign in_range   = (x_cnt < X_MAX) & (y_cnt < Y_MAX);
  assign running    = (state == RUN);
  assign fifo_rd_en = running & act & in_range & ~fifo_empty;
  assign uf_hit     = running & act & in_range & fifo_empty;

`ifdef LCD_FRAME_READER_COLORBAR_EN
  logic [2:0] bar_p;  // bar index of the pixel in flight

  // Classic 8-bar pattern, white through black.
  function automatic logic [RGBW-1:0] bar_rgb(input logic [2:0] idx);
    logic [RGBW-1:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) bar_p <= 3'd0;
    else     bar_p <= x_cnt[9:7];
  end

  assign fill_rgb_c = bar_rgb(bar_p);
`else
  assign fill_rgb_c = FILL_RGB;
`endif

  // Sync lock, position counters, output pipeline and underflow tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WAIT_SYNC;
      // Start as if v_valid were already high so a frame in progress at
      // reset release is not mistaken for a fresh frame.
      v_valid_d     <= 1'b1;
      h_valid_d     <= 1'b0;
      frame_start   <= 1'b0;
      x_cnt         <= '0;
      y_cnt         <= '0;
      de_p          <= 1'b0;
      rd_p          <= 1'b0;
      lcd_de        <= 1'b0;
      lcd_rgb       <= FILL_RGB;
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      v_valid_d   <= v_valid;
      h_valid_d   <= h_valid;
      frame_start <= vs_rise;

      case (state)
        WAIT_SYNC: if (vs_rise) state <= RUN;
        RUN:       state <= RUN;
        default:   state <= WAIT_SYNC;
      endcase

      if (vs_rise) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (running) begin
        if (h_fall) begin
          x_cnt <= '0;
          if (v_valid && (y_cnt != Y_MAX)) y_cnt <= y_cnt + YW'(1);
        end else if (act && (x_cnt != X_MAX)) begin
          x_cnt <= x_cnt + XW'(1);
        end
      end

      // Stage 1 captures the decision, stage 2 meets the FIFO data.
      de_p    <= act & in_range;
      rd_p    <= fifo_rd_en;
      lcd_de  <= de_p;
      lcd_rgb <= rd_p ? rgb565_to_888(fifo_dout) : fill_rgb_c;

      if (uf_hit) begin
        underflow <= 1'b1;
        if (underflow_cnt != UC_MAX) underflow_cnt <= underflow_cnt + UCW'(1);
      end
    end
  end

endmodule
